window_line_buffer: RTL

Parametrised streaming 3x3 neighbourhood generator for the pixel pipeline. It is the successor to the fixed 640x480, 4-line pixel-window buffers. It takes one pixel per accepted cycle in raster order and emits exactly one 3x3 window per image pixel, centred on every position of the frame. Border handling is selectable, and an end-of-frame flush produces the last row without waiting for the next frame. It sits between frame-buffer readout and the median, blur and edge stages.

---
 rtl/window_line_buffer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/window_line_buffer.sv
// window_line_buffer
// Streaming 3x3 neighbourhood generator. Accepts one pixel per transfer in
// raster order and emits one window per frame pixel, centred on every
// position, with zero-fill or edge-replicate borders and an end-of-frame
// flush that produces the last row without waiting for the next frame.
module window_line_buffer #(
   parameter int PIX_W   = 12,
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480,
   parameter int X_W     = 10,
   parameter int Y_W     = 9
) (
   input  logic               vgaClk,
   input  logic               resetN,
   input  logic               inValid,
   output logic               inReady,
   input  logic               inSof,
   input  logic [PIX_W-1:0]   inPixel,
   input  logic               borderMode,
   output logic               outValid,
   output logic               outSof,
   output logic [X_W-1:0]     outX,
   output logic [Y_W-1:0]     outY,
   output logic [9*PIX_W-1:0] outWindow
);

   typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} lineState_t;

   // One window column: index 0 = upper row, 1 = middle row, 2 = lower row.
   typedef logic [2:0][PIX_W-1:0] column_t;

   localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);
   localparam logic [X_W-1:0] X_ONE  = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

   lineState_t       state;
   logic [X_W-1:0]   inX;
   logic [Y_W-1:0]   inY;
   logic [X_W-1:0]   flushX;
   logic [Y_W-1:0]   eolY;
   logic             lastLine;
   logic             modeR;

   // Line RAMs: lineA holds line y-1, lineB holds line y-2 while line y streams in.
   logic [PIX_W-1:0] lineA [LINE_W];
   logic [PIX_W-1:0] lineB [LINE_W];

   column_t          colL;
   column_t          colM;
   column_t          colNew;
   column_t          winL;
   column_t          winM;
   column_t          winR;

   logic             xfer;
   logic             sofXfer;
   logic             pixXfer;
   logic [X_W-1:0]   rdAddr;
   logic [X_W-1:0]   wrAddr;

   logic             emit;
   logic             emitSof;
   logic [X_W-1:0]   emitX;
   logic [Y_W-1:0]   emitY;
   logic             lBord;
   logic             rBord;
   logic             uBord;
   logic             dBord;
   logic [9*PIX_W-1:0] winNext;

   // Replace the upper/lower tap of a column by the border value.
   function automatic column_t rowBorder(input column_t c, input logic topB,
                                         input logic botB, input logic repl);
      column_t r;
      r = c;
      if (topB) r[0] = repl ? c[1] : '0;
      if (botB) r[2] = repl ? c[1] : '0;
      return r;
   endfunction

   assign xfer    = inValid && inReady;
   assign sofXfer = xfer && inSof;
   assign pixXfer = xfer && !inSof;
   assign wrAddr  = inSof ? '0 : inX;

   // Line RAM read address: streaming column, column 0 preload at EOL, look-ahead column in FLUSH.
   always_comb begin
      rdAddr = inX;
      if (state == EOL) begin
         rdAddr = '0;
      end else if (state == FLUSH) begin
         rdAddr = (flushX == X_LAST) ? '0 : flushX + X_ONE;
      end
   end

   assign colNew[0] = lineB[rdAddr];
   assign colNew[1] = lineA[rdAddr];
   assign colNew[2] = inPixel;

   // Decide whether this cycle produces a window, its centre, and which edges are borders.
   always_comb begin
      emit  = 1'b0;
      emitX = inX - X_ONE;
      emitY = inY - Y_ONE;
      lBord = 1'b0;
      rBord = 1'b0;
      uBord = 1'b0;
      dBord = 1'b0;
      unique case (state)
         RUN: begin
            emit  = pixXfer && (inX != '0);
            lBord = (inX == X_ONE);
            uBord = (inY == Y_ONE);
         end
         EOL: begin
            emit  = 1'b1;
            emitX = X_LAST;
            emitY = eolY;
            rBord = 1'b1;
            uBord = (eolY == '0);
         end
         FLUSH: begin
            emit  = 1'b1;
            emitX = flushX;
            emitY = Y_LAST;
            lBord = (flushX == '0);
            rBord = (flushX == X_LAST);
            dBord = 1'b1;
         end
         default: ;
      endcase
      emitSof = emit && (emitX == '0) && (emitY == '0);
   end

   // Assemble the window: row borders first, then whole-column borders, so corners
   // pick up the corner pixel in replicate mode.
   always_comb begin
      winL = rowBorder(colL, uBord, dBord, modeR);
      winM = rowBorder(colM, uBord, dBord, modeR);
      winR = rowBorder(colNew, uBord, dBord, modeR);
      if (lBord) winL = modeR ? winM : '0;
      if (rBord) winR = modeR ? winM : '0;
      winNext = {winR, winM, winL};
   end

   // Line RAM write: the old line y-1 value shifts into lineB as the new pixel lands in lineA.
   always_ff @(posedge vgaClk) begin
      if (xfer) begin
         lineB[wrAddr] <= lineA[wrAddr];
         lineA[wrAddr] <= inPixel;
      end
   end

   // Control FSM, column shift registers and registered outputs.
   always_ff @(posedge vgaClk or negedge resetN) begin
      if (!resetN) begin
         state     <= FILL;
         inReady   <= 1'b1;
         inX       <= '0;
         inY       <= '0;
         flushX    <= '0;
         eolY      <= '0;
         lastLine  <= 1'b0;
         modeR     <= 1'b0;
         colL      <= '0;
         colM      <= '0;
         outValid  <= 1'b0;
         outSof    <= 1'b0;
         outX      <= '0;
         outY      <= '0;
         outWindow <= '0;
      end else begin
         outValid <= emit;
         outSof   <= emitSof;
         if (emit) begin
            outX      <= emitX;
            outY      <= emitY;
            outWindow <= winNext;
         end

         if (sofXfer) begin
            // The inSof pixel itself is (0,0) of the new frame.
            modeR    <= borderMode;
            inX      <= X_ONE;
            inY      <= '0;
            lastLine <= 1'b0;
            state    <= FILL;
            inReady  <= 1'b1;
         end else begin
            unique case (state)
               FILL: begin
                  if (pixXfer) begin
                     if (inX == X_LAST) begin
                        inX   <= '0;
                        inY   <= Y_ONE;
                        state <= RUN;
                     end else begin
                        inX <= inX + X_ONE;
                     end
                  end
               end
               RUN: begin
                  if (pixXfer) begin
                     colL <= colM;
                     colM <= colNew;
                     if (inX == X_LAST) begin
                        inX      <= '0;
                        eolY     <= inY - Y_ONE;
                        lastLine <= (inY == Y_LAST);
                        inY      <= (inY == Y_LAST) ? '0 : inY + Y_ONE;
                        state    <= EOL;
                        inReady  <= 1'b0;
                     end else begin
                        inX <= inX + X_ONE;
                     end
                  end
               end
               EOL: begin
                  if (lastLine) begin
                     // Preload column 0 of the last two lines so flush can start at centre 0.
                     colM   <= colNew;
                     flushX <= '0;
                     state  <= FLUSH;
                  end else begin
                     state   <= RUN;
                     inReady <= 1'b1;
                  end
               end
               FLUSH: begin
                  colL <= colM;
                  colM <= colNew;
                  if (flushX == X_LAST) begin
                     flushX   <= '0;
                     lastLine <= 1'b0;
                     state    <= FILL;
                     inReady  <= 1'b1;
                  end else begin
                     flushX <= flushX + X_ONE;
                  end
               end
               default: begin
                  state   <= FILL;
                  inReady <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
